// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback, drives datapath selects/enables, and traps on SYSTEM, illegal
// opcodes or memory handshake timeouts.
module multicycle_control_unit #(
  parameter int TIMEOUT       = 15,
  parameter bit ENABLE_CUSTOM = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       ir_write,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       custom_op,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  // Wait counter holds the number of unacknowledged request cycles so far.
  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            br_q, br_d;
  logic [1:0]      cause_q, cause_d;

  logic is_load, is_store, is_branch, is_jal, is_jalr, is_op, is_opimm;
  logic is_lui, is_auipc, is_system, is_custom, is_legal, timed_out;

  assign is_load   = (op_q == OPC_LOAD);
  assign is_store  = (op_q == OPC_STORE);
  assign is_branch = (op_q == OPC_BRANCH);
  assign is_jal    = (op_q == OPC_JAL);
  assign is_jalr   = (op_q == OPC_JALR);
  assign is_op     = (op_q == OPC_OP);
  assign is_opimm  = (op_q == OPC_OPIMM);
  assign is_lui    = (op_q == OPC_LUI);
  assign is_auipc  = (op_q == OPC_AUIPC);
  assign is_system = (op_q == OPC_SYSTEM);
  assign is_custom = ENABLE_CUSTOM && (op_q == OPC_CUSTOM0);
  assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr | is_op |
                     is_opimm | is_lui | is_auipc | is_custom;

  // Last permitted request cycle without an ack; never true when TIMEOUT is 0.
  assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  assign state = state_q;

  // State and instruction-context registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      op_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic and datapath controls, decoded from state and op_q.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = '0;
    br_d       = br_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    custom_op  = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          op_d     = opcode;
          state_d  = ST_DECODE;
        end else if (timed_out) begin
          state_d = ST_TRAP;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DECODE: begin
        custom_op = is_custom;
        if (is_system) begin
          state_d = ST_TRAP;
          cause_d = 2'b00;
        end else if (!is_legal) begin
          state_d = ST_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        custom_op = is_custom;
        br_d      = branch_taken;
        if (is_lui)        alu_src_a = 2'b10;
        else if (is_auipc) alu_src_a = 2'b01;
        alu_src_b = is_opimm | is_load | is_store | is_jalr | is_lui | is_auipc;
        if (is_op || is_custom) alu_op = 2'b10;
        else if (is_opimm)      alu_op = 2'b11;
        else if (is_branch)     alu_op = 2'b01;
        state_d = (is_load || is_store) ? ST_MEM : ST_WB;
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (timed_out) begin
          state_d = ST_TRAP;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WB: begin
        custom_op = is_custom;
        pc_write  = 1'b1;
        reg_write = !(is_store || is_branch);
        if (is_load)                mem_to_reg = 2'b01;
        else if (is_jal || is_jalr) mem_to_reg = 2'b10;
        if (is_jal || (is_branch && br_q)) pc_src = 2'b01;
        else if (is_jalr)                  pc_src = 2'b10;
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end

      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (custom-0 disabled/enabled,
// TIMEOUT=4) share one input stream and are checked every cycle against a
// behavioural model, with directed scenarios pinned by literal expectations.
module tb_multicycle_control_unit;

  localparam int TO = 4;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_BR = 7'b1100011;
  localparam logic [6:0] O_JALR = 7'b1100111, O_JAL = 7'b1101111, O_IMM = 7'b0010011;
  localparam logic [6:0] O_OP = 7'b0110011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_SYS = 7'b1110011, O_CUST = 7'b0001011;

  localparam int C_OP = 0, C_IMM = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5;
  localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_CUST = 9, C_SYS = 10, C_ILL = 11;

  localparam int S_RST = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5, S_T = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;

  logic       imem_req_w [2], ir_write_w [2], dmem_req_w [2], dmem_we_w [2];
  logic [1:0] alu_src_a_w [2], alu_op_w [2], mem_to_reg_w [2], pc_src_w [2], trap_cause_w [2];
  logic       alu_src_b_w [2], reg_write_w [2], pc_write_w [2], custom_op_w [2], trap_w [2];
  logic [2:0] state_w [2];
  logic [21:0] obs [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_dut
      multicycle_control_unit #(.TIMEOUT(TO), .ENABLE_CUSTOM(gi == 1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req_w[gi]), .ir_write(ir_write_w[gi]),
        .dmem_req(dmem_req_w[gi]), .dmem_we(dmem_we_w[gi]),
        .alu_src_a(alu_src_a_w[gi]), .alu_src_b(alu_src_b_w[gi]), .alu_op(alu_op_w[gi]),
        .mem_to_reg(mem_to_reg_w[gi]), .reg_write(reg_write_w[gi]), .pc_write(pc_write_w[gi]),
        .pc_src(pc_src_w[gi]), .custom_op(custom_op_w[gi]), .trap(trap_w[gi]),
        .trap_cause(trap_cause_w[gi]), .state(state_w[gi])
      );
      assign obs[gi] = {imem_req_w[gi], ir_write_w[gi], dmem_req_w[gi], dmem_we_w[gi],
                        alu_src_a_w[gi], alu_src_b_w[gi], alu_op_w[gi], mem_to_reg_w[gi],
                        reg_write_w[gi], pc_write_w[gi], pc_src_w[gi], custom_op_w[gi],
                        trap_w[gi], trap_cause_w[gi], state_w[gi]};
    end
  endgenerate

  // ---------------- behavioural model ----------------
  int         m_st [2];
  logic [6:0] m_op [2];
  int         m_cnt [2];
  logic       m_br [2];
  logic [1:0] m_cause [2];

  function automatic int cls(input logic [6:0] op, input bit ec);
    case (op)
      O_OP:    return C_OP;
      O_IMM:   return C_IMM;
      O_LOAD:  return C_LOAD;
      O_STORE: return C_STORE;
      O_BR:    return C_BR;
      O_JAL:   return C_JAL;
      O_JALR:  return C_JALR;
      O_LUI:   return C_LUI;
      O_AUIPC: return C_AUIPC;
      O_SYS:   return C_SYS;
      O_CUST:  return ec ? C_CUST : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  task automatic model_reset(input int i);
    m_st[i] = S_RST; m_op[i] = '0; m_cnt[i] = 0; m_br[i] = 1'b0; m_cause[i] = 2'b00;
  endtask

  // Advance both models by one clock edge using the inputs currently applied.
  task automatic model_step();
    int c;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else begin
        case (m_st[i])
          S_RST: begin m_st[i] = S_F; m_cnt[i] = 0; end
          S_F: begin
            if (imem_ack) begin m_op[i] = opcode; m_st[i] = S_D; end
            else if (m_cnt[i] + 1 == TO) begin m_st[i] = S_T; m_cause[i] = 2'b10; end
            else m_cnt[i]++;
          end
          S_D: begin
            c = cls(m_op[i], i == 1);
            if (c == C_SYS) begin m_st[i] = S_T; m_cause[i] = 2'b00; end
            else if (c == C_ILL) begin m_st[i] = S_T; m_cause[i] = 2'b01; end
            else m_st[i] = S_E;
          end
          S_E: begin
            c = cls(m_op[i], i == 1);
            m_br[i] = branch_taken;
            m_cnt[i] = 0;
            m_st[i] = (c == C_LOAD || c == C_STORE) ? S_M : S_W;
          end
          S_M: begin
            if (dmem_ack) m_st[i] = S_W;
            else if (m_cnt[i] + 1 == TO) begin m_st[i] = S_T; m_cause[i] = 2'b11; end
            else m_cnt[i]++;
          end
          S_W: begin m_st[i] = S_F; m_cnt[i] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [21:0] exp_bundle(input int i);
    logic [21:0] e;
    int c;
    e = '0;
    c = cls(m_op[i], i == 1);
    e[2:0] = m_st[i][2:0];
    case (m_st[i])
      S_F: begin e[21] = 1'b1; e[20] = imem_ack; end
      S_D: e[6] = (c == C_CUST);
      S_E: begin
        e[6] = (c == C_CUST);
        e[17:16] = (c == C_LUI) ? 2'd2 : (c == C_AUIPC) ? 2'd1 : 2'd0;
        e[15] = (c == C_IMM || c == C_LOAD || c == C_STORE || c == C_JALR ||
                 c == C_LUI || c == C_AUIPC);
        e[14:13] = (c == C_OP || c == C_CUST) ? 2'd2 : (c == C_IMM) ? 2'd3 :
                   (c == C_BR) ? 2'd1 : 2'd0;
      end
      S_M: begin e[19] = 1'b1; e[18] = (c == C_STORE); end
      S_W: begin
        e[6] = (c == C_CUST);
        e[9] = 1'b1;
        e[10] = !(c == C_STORE || c == C_BR);
        e[12:11] = (c == C_LOAD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
        e[8:7] = (c == C_JAL || (c == C_BR && m_br[i])) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
      end
      S_T: begin e[5] = 1'b1; e[4:3] = m_cause[i]; end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic compare_all();
    logic [21:0] e;
    for (int i = 0; i < 2; i++) begin
      e = exp_bundle(i);
      n_checks++;
      if (obs[i] !== e) begin
        n_fail++;
        $display("FAIL model_cmp dut%0d t=%0t: outputs got %h, expected %h", i, $time, obs[i], e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One clock: models follow the rising edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    chk("async_zero_dut0", 32'(obs[0]), 32'd0);
    chk("async_zero_dut1", 32'(obs[1]), 32'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH to WB with immediate imem_ack and a given
  // number of dmem wait cycles; reports cycle counts and the WB outputs.
  task automatic run_instr(input int idx, input logic [6:0] op, input logic br, input int dwait,
                           output int ncyc, output int nreq, output logic we_seen,
                           output logic [21:0] wb);
    bit done;
    ncyc = 0; nreq = 0; we_seen = 1'b0; wb = '0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      opcode = op; imem_ack = 1'b1; branch_taken = br;
      dmem_ack = (nreq == dwait);
      if (obs[idx][19]) begin nreq++; we_seen |= obs[idx][18]; end
      ncyc++;
      if (obs[idx][2:0] == 3'd5) begin wb = obs[idx]; done = 1'b1; end
      cycle();
    end
    if (!done) chk("run_instr_reached_wb", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] legal_tbl [9] = '{O_OP, O_IMM, O_LOAD, O_STORE, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC};

  initial begin
    int ncyc, nreq, cnt, trap_age, r;
    logic we;
    logic [21:0] wb;
    int exp_seq [6] = '{0, 1, 2, 3, 5, 1};

    model_reset(0);
    model_reset(1);
    @(negedge clk);
    chk("reset_outputs_zero", 32'(obs[0]), 32'd0);

    // Reset then OP with immediate imem_ack.
    opcode = O_OP; imem_ack = 1'b1; dmem_ack = 1'b0; branch_taken = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk("op_state_seq", 32'(obs[0][2:0]), 32'(exp_seq[k]));
      if (k == 1) chk("op_ir_write_fetch", 32'(obs[0][20]), 32'd1);
      if (k == 4) chk("op_wb_rw_pw_pcsrc_m2r", 32'({obs[0][10], obs[0][9], obs[0][8:7], obs[0][12:11]}),
                      32'b1_1_00_00);
      if (k < 5) cycle();
    end

    // LOAD with three dmem wait cycles.
    run_instr(0, O_LOAD, 1'b0, 3, ncyc, nreq, we, wb);
    chk("load_total_cycles", 32'(ncyc), 32'd8);
    chk("load_dmem_req_cycles", 32'(nreq), 32'd4);
    chk("load_dmem_we", 32'(we), 32'd0);
    chk("load_wb_mem_to_reg", 32'(wb[12:11]), 32'd1);

    // Taken branch, then not-taken branch.
    run_instr(0, O_BR, 1'b1, 0, ncyc, nreq, we, wb);
    chk("br_taken_cycles", 32'(ncyc), 32'd4);
    chk("br_taken_pc_src_rw", 32'({wb[8:7], wb[10]}), 32'b01_0);
    run_instr(0, O_BR, 1'b0, 0, ncyc, nreq, we, wb);
    chk("br_not_taken_pc_src_rw", 32'({wb[8:7], wb[10]}), 32'b00_0);

    // JAL then JALR.
    run_instr(0, O_JAL, 1'b0, 0, ncyc, nreq, we, wb);
    chk("jal_m2r_pcsrc", 32'({wb[12:11], wb[8:7]}), 32'b10_01);
    run_instr(0, O_JALR, 1'b0, 0, ncyc, nreq, we, wb);
    chk("jalr_m2r_pcsrc", 32'({wb[12:11], wb[8:7]}), 32'b10_10);

    // STORE with zero-wait memory.
    run_instr(0, O_STORE, 1'b0, 0, ncyc, nreq, we, wb);
    chk("store_cycles_we_rw", 32'({ncyc[3:0], we, wb[10]}), 32'({4'd5, 1'b1, 1'b0}));

    // custom-0: executes on the enabled instance, illegal on the other.
    run_instr(1, O_CUST, 1'b0, 0, ncyc, nreq, we, wb);
    chk("custom_wb_custom_op_rw", 32'({wb[6], wb[10]}), 32'b11);
    chk("custom_disabled_trap", 32'({obs[0][2:0], obs[0][5], obs[0][4:3]}), 32'b110_1_01);

    // SYSTEM traps with cause 00.
    do_reset();
    opcode = O_SYS;
    for (int k = 0; k < 4; k++) cycle();
    chk("system_trap", 32'({obs[0][2:0], obs[0][5], obs[0][4:3]}), 32'b110_1_00);

    // imem_ack never arrives: four request cycles, then sticky TRAP cause 10.
    do_reset();
    imem_ack = 1'b0;
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (obs[0][21]) cnt++;
      cycle();
    end
    chk("imem_timeout_req_cycles", 32'(cnt), 32'd4);
    chk("imem_timeout_trap_held", 32'({obs[0][2:0], obs[0][5], obs[0][4:3]}), 32'b110_1_10);

    // Reset out of TRAP clears the trap and refetches.
    async_reset();
    cycle();
    chk("refetch_after_trap", 32'({obs[0][2:0], obs[0][21], obs[0][5]}), 32'b001_1_0);

    // Reset in the middle of a MEM wait.
    opcode = O_LOAD; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("mid_mem_state", 32'(obs[0][2:0]), 32'd4);
    async_reset();
    cycle();
    chk("refetch_after_mem_reset", 32'({obs[0][2:0], obs[0][21]}), 32'b001_1);

    // Randomised traffic, including stray acks and occasional resets.
    trap_age = 0;
    for (int n = 0; n < 4000; n++) begin
      if (trap_age >= 3 || $urandom_range(0, 499) == 0) begin
        if ($urandom_range(0, 1) == 0) async_reset();
        else do_reset();
        trap_age = 0;
      end else begin
        r = $urandom_range(0, 39);
        if (r < 36) opcode = legal_tbl[r % 9];
        else if (r == 36) opcode = O_CUST;
        else if (r == 37) opcode = O_SYS;
        else opcode = 7'($urandom);
        imem_ack = ($urandom_range(0, 99) < 60);
        dmem_ack = ($urandom_range(0, 99) < 60);
        branch_taken = 1'($urandom);
        cycle();
        if (m_st[0] == S_T || m_st[1] == S_T) trap_age++;
        else trap_age = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RISC-V RV32I control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath select and enable lines for every base opcode class. It handshakes with instruction and data memory and traps on illegal opcodes or memory timeouts. It sits between the instruction register/memory ports and the register file, ALU and PC logic of the CPU core.

## Interface
- TIMEOUT, 15: maximum request cycles waited for imem_ack/dmem_ack; 0 disables timeout.
- ENABLE_CUSTOM, 0: 1 decodes custom-0 (7'b0001011) as R-type with custom_op=1; 0 treats it as illegal.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  instr[6:0]; sampled only in FETCH on the imem_ack cycle.
- imem_ack  input  1  instruction word valid.
- dmem_ack  input  1  data access complete.
- branch_taken  input  1  ALU compare result; sampled in EXEC.
- imem_req  output  1  fetch request.
- ir_write  output  1  load instruction register.
- dmem_req / dmem_we  output  1 / 1  data request; write when dmem_we=1.
- alu_src_a  output  2  00 rs1, 01 PC, 10 zero.
- alu_src_b  output  1  0 rs2, 1 imm.
- alu_op  output  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct.
- mem_to_reg  output  2  00 ALU, 01 load data, 10 PC+4.
- reg_write, pc_write  output  1, 1  register-file and PC write enables.
- pc_src  output  2  00 PC+4, 01 PC+imm, 10 ALU result.
- custom_op  output  1  current instruction is custom-0.
- trap  output  1  sticky fault.
- trap_cause  output  2  00 SYSTEM, 01 illegal, 10 imem timeout, 11 dmem timeout.
- state  output  3  current state, for debug.

## Operation
- States and encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- RESET lasts 1 cycle after rst_n deasserts, then FETCH.
- FETCH: imem_req=1 is held until imem_ack. On the ack cycle, ir_write=1 and opcode is latched into op_q; next state is DECODE.
- DECODE: classifies op_q. SYSTEM (1110011) goes to TRAP with cause 00. An unknown opcode goes to TRAP with cause 01. Everything else goes to EXEC.
- EXEC (1 cycle) drives the ALU selects:
  - OP: rs1/rs2, alu_op 10.
  - OP_IMM: rs1/imm, alu_op 11.
  - LOAD, STORE, JALR: rs1/imm, alu_op 00.
  - BRANCH: rs1/rs2, alu_op 01. branch_taken is registered.
  - LUI: zero/imm, alu_op 00.
  - AUIPC: PC/imm, alu_op 00.
  - JAL: don't-care, alu_op 00.
  - Next state: LOAD/STORE go to MEM; all others go to WB.
- MEM: dmem_req=1 is held until dmem_ack. dmem_we=1 for STORE. On ack, next state is WB.
- WB (1 cycle): pc_write=1. reg_write=1 for all classes except STORE and BRANCH.
  - mem_to_reg: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL or a taken branch, 10 for JALR, 00 otherwise.
  - Next state: FETCH.
- Outputs are combinational from state and op_q. All outputs not listed for a state are 0.
- TRAP: trap=1 and trap_cause is held. No requests or writes are issued. The FSM leaves TRAP only via rst_n.
- Timeout (TIMEOUT>0): a wait counter clears on entry to FETCH/MEM and increments each request cycle without ack.
  - An ack on request cycle TIMEOUT is accepted.
  - No ack by the end of cycle TIMEOUT goes to TRAP (cause 10 from FETCH, 11 from MEM); the request drops in the TRAP cycle.

## Timing
- Reset values: state=RESET; all outputs 0, including trap and trap_cause. op_q=0, wait counter=0, registered branch_taken=0.
- Asserting rst_n mid-instruction forces RESET asynchronously. Outputs go to 0 immediately, with no partial writes after the reset edge.
- Latency with zero-wait memory (ack in the first request cycle):
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR/BRANCH: 4 cycles, FETCH to WB.
  - LOAD/STORE: 5 cycles.
  - Each memory wait cycle adds 1.
- Ack outside the matching request state is ignored.
- Requests stay asserted and stable until ack; they are never withdrawn except on timeout or reset.

## Test plan
- Reset then OP (0110011), imem_ack immediate:
  - States are 0,1,2,3,5,1.
  - ir_write pulses in FETCH.
  - WB has reg_write=1, pc_write=1, pc_src=00, mem_to_reg=00.
- LOAD with dmem_ack after 3 wait cycles:
  - dmem_req high for 4 cycles with dmem_we=0.
  - WB has mem_to_reg=01; total 8 cycles.
- BRANCH with branch_taken=1, then a second BRANCH with branch_taken=0:
  - pc_src=01 then 00.
  - reg_write=0 in both WBs.
- JAL then JALR: WB has mem_to_reg=10, with pc_src=01 and 10 respectively.
- Opcode 0001011 with ENABLE_CUSTOM=0: TRAP with cause 01. With ENABLE_CUSTOM=1: custom_op=1 and reg_write=1 in WB.
- TIMEOUT=4 timing and reset:
  - imem_ack never arrives: imem_req high for 4 cycles, then TRAP with cause 10, held.
  - rst_n pulse mid-MEM: outputs 0 at once, trap cleared, refetch.
